ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes decoded operands and the M-extension operation, runs a 32-iteration radix-2 shift-add multiply or restoring divide, and drives `stall` to freeze the PC, IF/ID and ID/EX registers until the result is ready. The result is presented alongside the destination register for the EX/MEM register to capture.

---
 rtl/ex_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Uses radix-2 shift-add multiply and restoring divide on operand magnitudes, then fixes the sign.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      resultRd
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [4:0]      CNT_LAST = 5'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } StateType;

    StateType          state;
    logic [4:0]        count;
    logic [2:0]        opReg;
    logic [4:0]        rdReg;
    logic              negReg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;

    logic              aSigned;
    logic              bSigned;
    logic              aNeg;
    logic              bNeg;
    logic [XLEN-1:0]   absA;
    logic [XLEN-1:0]   absB;
    logic              startNeg;
    logic              divZero;
    logic              divOverflow;
    logic              special;
    logic [XLEN-1:0]   specialResult;
    logic [2*XLEN-1:0] initAcc;
    logic [XLEN-1:0]   initMcand;

    // Operand decode at acceptance: magnitudes, result sign and the divide shortcuts.
    always_comb begin
        aSigned       = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                        (op == OP_DIV) || (op == OP_REM);
        bSigned       = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        aNeg          = aSigned && rs1Data[XLEN-1];
        bNeg          = bSigned && rs2Data[XLEN-1];
        absA          = aNeg ? -rs1Data : rs1Data;
        absB          = bNeg ? -rs2Data : rs2Data;
        startNeg      = (op[2] && op[1]) ? aNeg : (aNeg ^ bNeg);
        divZero       = op[2] && (rs2Data == '0);
        divOverflow   = ((op == OP_DIV) || (op == OP_REM)) &&
                        (rs1Data == MIN_NEG) && (rs2Data == '1);
        special       = divZero || divOverflow;
        specialResult = '0;
        if (divZero) begin
            specialResult = op[1] ? rs1Data : '1;
        end else if (divOverflow) begin
            specialResult = op[1] ? '0 : MIN_NEG;
        end
        initAcc   = op[2] ? {{XLEN{1'b0}}, absA} : {{XLEN{1'b0}}, absB};
        initMcand = op[2] ? absB : absA;
    end

    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulNext;
    logic [XLEN:0]     divTop;
    logic              divFits;
    logic [2*XLEN-1:0] divNext;
    logic [2*XLEN-1:0] stepAcc;
    logic [2*XLEN-1:0] signedProd;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   finalResult;

    // One iteration; on the last one this also yields the sign-fixed final result.
    always_comb begin
        mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
        mulNext = {mulSum, acc[XLEN-1:1]};

        divTop  = acc[2*XLEN-1:XLEN-1];
        divFits = divTop >= {1'b0, mcand};
        if (divFits) begin
            divNext = {divTop[XLEN-1:0] - mcand, acc[XLEN-2:0], 1'b1};
        end else begin
            divNext = {divTop[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end

        stepAcc    = opReg[2] ? divNext : mulNext;
        signedProd = negReg ? -stepAcc : stepAcc;
        quot       = stepAcc[XLEN-1:0];
        rem        = stepAcc[2*XLEN-1:XLEN];

        finalResult = '0;
        case (opReg)
            OP_MUL:    finalResult = signedProd[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  finalResult = signedProd[2*XLEN-1:XLEN];
            OP_DIV:    finalResult = negReg ? -quot : quot;
            OP_DIVU:   finalResult = quot;
            OP_REM:    finalResult = negReg ? -rem : rem;
            OP_REMU:   finalResult = rem;
            default:   finalResult = '0;
        endcase
    end

    assign stall = ((state == IDLE) && start && !flush) || (state == BUSY);

    // Control FSM; flush abandons the operation without touching the visible result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            opReg    <= '0;
            rdReg    <= '0;
            negReg   <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            done     <= 1'b0;
            result   <= '0;
            resultRd <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        opReg  <= op;
                        rdReg  <= rd;
                        negReg <= startNeg;
                        acc    <= initAcc;
                        mcand  <= initMcand;
                        count  <= '0;
                        if (special) begin
                            result   <= specialResult;
                            resultRd <= rd;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= stepAcc;
                        if (count == CNT_LAST) begin
                            result   <= finalResult;
                            resultRd <= rdReg;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count <= count + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: results, latency, stall length, flush and reset.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rd;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  resultRd;

    int          checks;
    int          errors;
    int          waitCnt;
    int          stallCnt;
    int          doneCnt;
    logic [31:0] obsResult;
    logic [4:0]  obsRd;
    logic        doneStall;
    logic [31:0] lastResult;

    ex_muldiv #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1Data  (rs1Data),
        .rs2Data  (rs2Data),
        .rd       (rd),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .resultRd (resultRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction at a negedge and follow it to its done pulse (bounded wait).
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rdIn, input bit holdStart);
        bit seenDone;
        @(negedge clk);
        op      = opIn;
        rs1Data = a;
        rs2Data = b;
        rd      = rdIn;
        start   = 1'b1;
        #1;
        stallCnt  = stall ? 1 : 0;
        waitCnt   = 0;
        seenDone  = 1'b0;
        obsResult = 32'hDEAD_BEEF;
        obsRd     = 5'h1F;
        doneStall = 1'b1;
        while (!seenDone && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
            if (done) begin
                seenDone  = 1'b1;
                obsResult = result;
                obsRd     = resultRd;
                doneStall = stall;
                if (!holdStart) start = 1'b0;
            end else if (stall) begin
                stallCnt++;
            end
            if (waitCnt == 1) begin
                rs1Data = $urandom;
                rs2Data = $urandom;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] opIn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rdIn, input bit holdStart,
                         input logic [31:0] expResult, input int expLat);
        applyStimulus(opIn, a, b, rdIn, holdStart);
        checkOutput({tag, " result"}, obsResult, expResult);
        checkOutput({tag, " resultRd"}, {27'd0, obsRd}, {27'd0, rdIn});
        checkOutput({tag, " latency"}, 32'(waitCnt), 32'(expLat));
        checkOutput({tag, " stallCycles"}, 32'(stallCnt), 32'(expLat));
        checkOutput({tag, " stallInDone"}, {31'd0, doneStall}, 32'd0);
        lastResult = expResult;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        lastResult = 32'd0;
        rst        = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        op         = 3'd0;
        rs1Data    = 32'd0;
        rs2Data    = 32'd0;
        rd         = 5'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset resultRd", {27'd0, resultRd}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        runOp("MUL 7*-3",       3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  1'b0, 32'hFFFF_FFEB, 33);
        runOp("MULH 7*-3",      3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd6,  1'b0, 32'hFFFF_FFFF, 33);
        runOp("MULHU max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1'b0, 32'hFFFF_FFFE, 33);
        runOp("DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  1'b0, 32'hFFFF_FFFD, 33);
        runOp("REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  1'b0, 32'hFFFF_FFFF, 33);
        runOp("DIVU 100/7",     3'd5, 32'd100,       32'd7,         5'd10, 1'b0, 32'd14,        33);
        runOp("REMU 100/7",     3'd7, 32'd100,       32'd7,         5'd11, 1'b0, 32'd2,         33);
        runOp("DIV 5/0",        3'd4, 32'd5,         32'd0,         5'd12, 1'b0, 32'hFFFF_FFFF, 1);
        runOp("REM 5/0",        3'd6, 32'd5,         32'd0,         5'd13, 1'b0, 32'd5,         1);
        runOp("DIV overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0, 32'h8000_0000, 1);
        runOp("REM overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0, 32'd0,         1);

        // start stays high through DONE; the following MULHSU must be a separate, single completion
        runOp("REMU held",      3'd7, 32'd100,       32'd7,         5'd16, 1'b1, 32'd2,         33);
        runOp("MULHSU -1*2",    3'd2, 32'hFFFF_FFFF, 32'd2,         5'd17, 1'b0, 32'hFFFF_FFFF, 33);

        // flush at BUSY cycle 10
        @(negedge clk);
        op      = 3'd5;
        rs1Data = 32'd1000;
        rs2Data = 32'd3;
        rd      = 5'd18;
        start   = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush done", {31'd0, done}, 32'd0);
        checkOutput("flush wins stall", {31'd0, stall}, 32'd0);
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("flush idle stall", {31'd0, stall}, 32'd0);
        checkOutput("flush result kept", result, lastResult);
        checkOutput("flush resultRd kept", {27'd0, resultRd}, 32'd17);
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("flush no done", 32'(doneCnt), 32'd0);

        runOp("MUL after flush", 3'd0, 32'h1234_5678, 32'h0000_0010, 5'd19, 1'b0, 32'h2345_6780, 33);

        // reset in the middle of BUSY
        @(negedge clk);
        op      = 3'd3;
        rs1Data = 32'hFFFF_FFFF;
        rs2Data = 32'h0000_0003;
        rd      = 5'd20;
        start   = 1'b1;
        repeat (6) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("midReset done", {31'd0, done}, 32'd0);
        checkOutput("midReset result", result, 32'd0);
        checkOutput("midReset resultRd", {27'd0, resultRd}, 32'd0);
        checkOutput("midReset stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        runOp("MULH min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd21, 1'b0, 32'h4000_0000, 33);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
